// File: rtl/pmem_stream_loader.sv
// pmem_stream_loader
// Receives a program image as a byte stream (valid/ready), assembles 12-bit
// instructions from LO/HI byte pairs, writes them into program memory through
// the LE/LA/LI load port, and validates a trailing XOR checksum. The result is
// reported as the level signals load_done / load_err, which are held until the
// next start.
//
// Image format: HDR (word count N, 1..PMEM_DEPTH), N x {LO, HI}, CSUM.
// HI[7:4] must be zero, and CSUM must equal the XOR of HDR and every LO/HI byte.

module pmem_stream_loader #(
    parameter int PMEM_DEPTH = 10,
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               load_en,
    output logic [ADDR_W-1:0]  load_addr,
    output logic [INSTR_W-1:0] load_instr,
    output logic               load_done,
    output logic               load_err,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LO,
        S_HI,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    // Datapath state.
    logic [ADDR_W-1:0] word_count;   // index of the word being assembled
    logic [ADDR_W-1:0] word_total;   // N from the header
    logic [7:0]        lo_byte;      // low byte of the word being assembled
    logic [7:0]        run_xor;      // running checksum over HDR and all LO/HI bytes

    // Decoded conditions.
    logic accept;
    logic can_start;
    logic hdr_ok;
    logic hi_ok;
    logic more_words;

    // Next values of the registered status outputs.
    logic in_ready_nxt;
    logic load_en_nxt;
    logic load_done_nxt;
    logic load_err_nxt;
    logic busy_nxt;

    // in_ready is itself a registered decode of the state, so a byte is taken
    // exactly when the current state can consume it.
    assign accept     = in_valid && in_ready;
    assign can_start  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign hdr_ok     = (in_data != 8'd0) && (int'(in_data) <= PMEM_DEPTH);
    assign hi_ok      = (in_data[7:4] == 4'd0);
    // The header check keeps N below 2^ADDR_W, so the increment never wraps.
    assign more_words = ((word_count + 1'b1) < word_total);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: byte-driven sequencing of the image format.
    // NOTE: the default assignment at the top of a combinational block
    // guarantees every path assigns state_nxt, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_nxt = hdr_ok ? S_LO : S_ERR;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_nxt = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_nxt = hi_ok ? S_WRITE : S_ERR;
                end
            end
            S_WRITE: begin
                state_nxt = more_words ? S_LO : S_CSUM;
            end
            S_CSUM: begin
                if (accept) begin
                    state_nxt = (in_data == run_xor) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: status outputs are computed from the next state and
    // registered, so they line up with the state they describe.
    always_comb begin
        in_ready_nxt  = 1'b0;
        load_en_nxt   = 1'b0;
        load_done_nxt = 1'b0;
        load_err_nxt  = 1'b0;
        busy_nxt      = 1'b1;
        case (state_nxt)
            S_IDLE: begin
                busy_nxt = 1'b0;
            end
            S_HDR, S_LO, S_HI, S_CSUM: begin
                in_ready_nxt = 1'b1;
            end
            S_WRITE: begin
                load_en_nxt = 1'b1;
            end
            S_DONE: begin
                load_done_nxt = 1'b1;
                busy_nxt      = 1'b0;
            end
            S_ERR: begin
                load_err_nxt = 1'b1;
                busy_nxt     = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            load_en   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            load_en   <= load_en_nxt;
            load_done <= load_done_nxt;
            load_err  <= load_err_nxt;
            busy      <= busy_nxt;
        end
    end

    // Datapath: word counter, header count, byte assembly, running checksum and
    // the load address/instruction registers (which hold outside WRITE).
    // NOTE: every datapath register is reset, not just the ones that are visible
    // on ports, so a reset in the middle of a load leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
            word_total <= '0;
            lo_byte    <= '0;
            run_xor    <= '0;
            load_addr  <= '0;
            load_instr <= '0;
        end else begin
            if (can_start) begin
                word_count <= '0;
                run_xor    <= '0;
            end
            if (accept) begin
                case (state)
                    S_HDR: begin
                        word_total <= ADDR_W'(in_data);
                        run_xor    <= in_data;
                    end
                    S_LO: begin
                        lo_byte <= in_data;
                        run_xor <= run_xor ^ in_data;
                    end
                    S_HI: begin
                        run_xor <= run_xor ^ in_data;
                        if (hi_ok) begin
                            load_addr  <= word_count;
                            load_instr <= INSTR_W'({in_data[3:0], lo_byte});
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (state == S_WRITE) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pmem_stream_loader.sv
// Testbench for pmem_stream_loader.
// A transaction-level model parses each byte image into the list of program
// memory writes it must produce, the number of bytes the loader must take, and
// the final status. One compare process checks every load_en pulse against
// that list; the directed tests then check terminal status, timing and a few
// literal values.

module tb_pmem_stream_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [11:0] load_instr;
    logic        load_done;
    logic        load_err;
    logic        busy;

    pmem_stream_loader #(
        .PMEM_DEPTH (10),
        .ADDR_W     (8),
        .INSTR_W    (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_instr (load_instr),
        .load_done  (load_done),
        .load_err   (load_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] instr;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] stream[$];
    wr_t        exp_q[$];
    wr_t        act_q[$];
    wr_t        ref_q[$];
    bit         exp_done;
    bit         exp_err;
    int         exp_bytes;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: parse the first 'limit' bytes of the image.
    task automatic model(input int limit);
        int         avail;
        int         n;
        logic [7:0] x;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        avail = (limit < stream.size()) ? limit : stream.size();
        if (avail < 1) begin
            exp_bytes = 0;
            return;
        end
        n = int'(stream[0]);
        x = stream[0];
        if (n < 1 || n > 10) begin
            exp_err   = 1'b1;
            exp_bytes = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            int         p;
            logic [7:0] hi;
            wr_t        wr;
            p = 1 + 2 * w;
            if (p + 1 >= avail) begin
                exp_bytes = avail;
                return;
            end
            hi = stream[p + 1];
            x  = x ^ stream[p] ^ hi;
            if (hi[7:4] != 4'd0) begin
                exp_err   = 1'b1;
                exp_bytes = p + 2;
                return;
            end
            wr.addr  = 8'(w);
            wr.instr = {hi[3:0], stream[p]};
            exp_q.push_back(wr);
        end
        if (1 + 2 * n >= avail) begin
            exp_bytes = avail;
            return;
        end
        exp_bytes = 2 + 2 * n;
        if (stream[1 + 2 * n] == x) exp_done = 1'b1;
        else                        exp_err  = 1'b1;
    endtask

    // Full 10-word image with a correct (or deliberately corrupted) checksum.
    task automatic build_full(input bit bad_csum);
        logic [7:0] x;
        stream.delete();
        stream.push_back(8'd10);
        x = 8'd10;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'(i * 37 + 5);
            hi = {4'd0, 4'(i + 3)};
            stream.push_back(lo);
            stream.push_back(hi);
            x = x ^ lo ^ hi;
        end
        stream.push_back(bad_csum ? (x ^ 8'h10) : x);
    endtask

    // Compare process: every write must match the next modelled write.
    always @(negedge clk) begin
        if (rst) begin
            check("done_err_exclusive", {31'd0, load_done & load_err}, 32'd0);
            if (load_en) begin
                wr_t a;
                a.addr  = load_addr;
                a.instr = load_instr;
                act_q.push_back(a);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {24'd0, load_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", {24'd0, a.addr}, {24'd0, e.addr});
                    check("write_instr", {20'd0, a.instr}, {20'd0, e.instr});
                end
            end
        end
    end

    // Start a load, stream up to 'limit' bytes, and, when terminal, check status.
    task automatic run_image(input int gap, input bit spam, input int limit, input bit terminal);
        int idx;
        int cyc;
        int lat;
        act_q.delete();
        model(limit);
        // start together with a valid first byte: only start may act.
        @(negedge clk);
        check("ready_before_start", {31'd0, in_ready}, 32'd0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = stream[0];
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_after_start", {31'd0, in_ready}, 32'd1);
        check("status_cleared", {30'd0, load_done, load_err}, 32'd0);
        idx = 0;
        cyc = 0;
        while (idx < exp_bytes && cyc < 2000) begin
            bit acc;
            in_valid = (gap == 0) || ($urandom_range(99, 0) >= gap);
            in_data  = in_valid ? stream[idx] : 8'($urandom);
            start    = spam && busy && ($urandom_range(3, 0) == 0);
            acc      = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (idx < exp_bytes) check("drive_timeout", 32'(idx), 32'(exp_bytes));
        if (terminal) begin
            lat = 0;
            while (!(load_done || load_err) && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("status_latency", 32'(lat), 32'd0);
            check("load_done", {31'd0, load_done}, {31'd0, exp_done});
            check("load_err", {31'd0, load_err}, {31'd0, exp_err});
            repeat (3) @(negedge clk);
            check("ready_idle_end", {31'd0, in_ready}, 32'd0);
            check("busy_end", {31'd0, busy}, 32'd0);
            check("writes_pending", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #13;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_load_en", {31'd0, load_en}, 32'd0);
        check("rst_load_addr", {24'd0, load_addr}, 32'd0);
        check("rst_load_instr", {20'd0, load_instr}, 32'd0);
        check("rst_status", {29'd0, load_done, load_err, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // T1: two-word image, gap-free.
        stream = '{8'h02, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
        run_image(0, 1'b0, 99, 1'b1);
        check("t1_nwrites", 32'(act_q.size()), 32'd2);
        if (act_q.size() == 2) begin
            check("t1_w0_addr", {24'd0, act_q[0].addr}, 32'h0);
            check("t1_w0_instr", {20'd0, act_q[0].instr}, 32'h1A5);
            check("t1_w1_addr", {24'd0, act_q[1].addr}, 32'h1);
            check("t1_w1_instr", {20'd0, act_q[1].instr}, 32'h03C);
        end
        check("t1_done", {30'd0, load_done, load_err}, 32'h2);
        check("t1_addr_held", {24'd0, load_addr}, 32'h1);

        // T2: header out of range, both ends.
        stream = '{8'h00, 8'h11, 8'h01};
        run_image(0, 1'b0, 99, 1'b1);
        check("t2a_err", {30'd0, load_done, load_err}, 32'h1);
        check("t2a_nwrites", 32'(act_q.size()), 32'd0);
        stream = '{8'h0B, 8'h11, 8'h01};
        run_image(0, 1'b0, 99, 1'b1);
        check("t2b_err", {30'd0, load_done, load_err}, 32'h1);
        check("t2b_nwrites", 32'(act_q.size()), 32'd0);

        // T3: bad HI byte on word 0, then a good image clears the error.
        stream = '{8'h01, 8'h22, 8'h15, 8'h36};
        run_image(0, 1'b0, 99, 1'b1);
        check("t3_err", {30'd0, load_done, load_err}, 32'h1);
        check("t3_nwrites", 32'(act_q.size()), 32'd0);
        stream = '{8'h02, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'h9A};
        run_image(0, 1'b0, 99, 1'b1);
        check("t3_recover", {30'd0, load_done, load_err}, 32'h2);

        // T4: checksum off by one bit.
        build_full(1'b1);
        run_image(0, 1'b0, 99, 1'b1);
        check("t4_err", {30'd0, load_done, load_err}, 32'h1);
        check("t4_nwrites", 32'(act_q.size()), 32'd10);

        // T5: gap-free reference, then ~50% gaps with start spam while busy.
        build_full(1'b0);
        run_image(0, 1'b0, 99, 1'b1);
        ref_q = act_q;
        check("t5_ref_nwrites", 32'(ref_q.size()), 32'd10);
        run_image(50, 1'b1, 99, 1'b1);
        check("t5_done", {30'd0, load_done, load_err}, 32'h2);
        check("t5_nwrites", 32'(act_q.size()), 32'(ref_q.size()));
        if (act_q.size() == ref_q.size()) begin
            for (int i = 0; i < ref_q.size(); i++) begin
                check("t5_same_addr", {24'd0, act_q[i].addr}, {24'd0, ref_q[i].addr});
                check("t5_same_instr", {20'd0, act_q[i].instr}, {20'd0, ref_q[i].instr});
            end
        end

        // T6: asynchronous reset while waiting for HI of word 3.
        build_full(1'b0);
        run_image(0, 1'b0, 8, 1'b0);
        check("t6_pre_writes", 32'(act_q.size()), 32'd3);
        check("t6_in_hi_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_addr", {24'd0, load_addr}, 32'd0);
        check("t6_rst_instr", {20'd0, load_instr}, 32'd0);
        check("t6_rst_status", {29'd0, load_en, load_done, load_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_image(0, 1'b0, 99, 1'b1);
        check("t6_done", {30'd0, load_done, load_err}, 32'h2);
        check("t6_nwrites", 32'(act_q.size()), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
